// File: rtl/writeback_unit.sv
// Writeback stage: holds one execute and one load result, formats load data,
// arbitrates with bounded starvation of EX and drives the register-file write port.
module writeback_unit #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [1:0]            mem_offset,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] dataD,
  output logic [31:0]           retire_count
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                  r_ex_full, r_mem_full;
  logic [ADDR_WIDTH-1:0] r_ex_rd, r_mem_rd;
  logic [DATA_WIDTH-1:0] r_ex_data, r_mem_data;
  logic [3:0]            r_starve;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic [31:0]           r_retire;

  logic                  w_ex_grant, w_mem_grant;
  logic                  w_ex_acc, w_mem_acc;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_fmt;

  // EX wins only when alone or once MEM has won LIMIT times in a row against it
  assign w_ex_grant  = r_ex_full & (~r_mem_full | (r_starve == LIMIT));
  assign w_mem_grant = r_mem_full & ~w_ex_grant;

  assign ex_ready  = rst_n & (~r_ex_full  | w_ex_grant);
  assign mem_ready = rst_n & (~r_mem_full | w_mem_grant);
  assign w_ex_acc  = ex_valid  & ex_ready;
  assign w_mem_acc = mem_valid & mem_ready;

  always_comb begin
    w_byte = mem_rdata[{mem_offset, 3'b000} +: 8];
    w_half = mem_rdata[{mem_offset[1], 4'b0000} +: 16];
    case (mem_size)
      2'd0:    w_fmt = {{(DATA_WIDTH-8){~mem_unsigned & w_byte[7]}}, w_byte};
      2'd1:    w_fmt = {{(DATA_WIDTH-16){~mem_unsigned & w_half[15]}}, w_half};
      default: w_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_full  <= 1'b0;
      r_ex_rd    <= '0;
      r_ex_data  <= '0;
      r_mem_full <= 1'b0;
      r_mem_rd   <= '0;
      r_mem_data <= '0;
      r_starve   <= '0;
    end else begin
      if (w_ex_acc) begin
        r_ex_full <= 1'b1;
        r_ex_rd   <= ex_rd;
        r_ex_data <= ex_data;
      end else if (w_ex_grant) begin
        r_ex_full <= 1'b0;
      end
      if (w_mem_acc) begin
        r_mem_full <= 1'b1;
        r_mem_rd   <= mem_rd;
        r_mem_data <= w_fmt;
      end else if (w_mem_grant) begin
        r_mem_full <= 1'b0;
      end
      // only MEM wins over a waiting EX count as starvation
      if (w_ex_grant)
        r_starve <= '0;
      else if (w_mem_grant & r_ex_full)
        r_starve <= r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen    <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
      r_retire <= '0;
    end else if (w_ex_grant) begin
      r_wen    <= (r_ex_rd != '0);
      r_rd     <= r_ex_rd;
      r_data   <= r_ex_data;
      r_retire <= r_retire + 32'd1;
    end else if (w_mem_grant) begin
      r_wen    <= (r_mem_rd != '0);
      r_rd     <= r_mem_rd;
      r_data   <= r_mem_data;
      r_retire <= r_retire + 32'd1;
    end else begin
      r_wen <= 1'b0;
    end
  end

  assign wen          = r_wen;
  assign rd           = r_rd;
  assign dataD        = r_data;
  assign retire_count = r_retire;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic, all checked
// against a queue-based model of pending results and the starvation rule.
module tb_writeback_unit;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0, mem_valid = 1'b0;
  logic          ex_ready, mem_ready;
  logic [AW-1:0] ex_rd = '0, mem_rd = '0;
  logic [DW-1:0] ex_data = '0, mem_rdata = '0;
  logic [1:0]    mem_size = '0, mem_offset = '0;
  logic          mem_unsigned = 1'b0;
  logic          wen;
  logic [AW-1:0] rd;
  logic [DW-1:0] dataD;
  logic [31:0]   retire_count;

  always #5 clk = ~clk;

  writeback_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_offset(mem_offset),
    .wen(wen), .rd(rd), .dataD(dataD), .retire_count(retire_count)
  );

  typedef struct {
    logic [AW-1:0] rd;
    logic [31:0]   d;
  } res_t;

  res_t        exq[$];
  res_t        mq[$];
  int          streak;
  logic        e_wen;
  logic [AW-1:0] e_rd;
  logic [31:0] e_data, e_cnt;
  int          checks = 0, errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(logic [31:0] w, int sz, bit u, int off);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!u && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic model_clear();
    exq.delete();
    mq.delete();
    streak = 0;
    e_wen  = 1'b0;
    e_rd   = '0;
    e_data = '0;
    e_cnt  = '0;
  endtask

  // One clock: check last edge's outputs, drive inputs, check ready, advance model.
  task automatic cycle(bit ev, logic [AW-1:0] erd, logic [31:0] ed,
                       bit mv, logic [AW-1:0] mrd, logic [31:0] md,
                       logic [1:0] msz, bit mu, logic [1:0] moff);
    int   win;
    bit   he, hm;
    res_t it;
    @(negedge clk);
    chk("wen", 32'(wen), 32'(e_wen));
    chk("rd", 32'(rd), 32'(e_rd));
    chk("dataD", dataD, e_data);
    chk("retire_count", retire_count, e_cnt);
    ex_valid = ev; ex_rd = erd; ex_data = ed;
    mem_valid = mv; mem_rd = mrd; mem_rdata = md;
    mem_size = msz; mem_unsigned = mu; mem_offset = moff;
    he = (exq.size() != 0);
    hm = (mq.size() != 0);
    win = 0;
    if (he && hm)  win = (streak == LIM) ? 1 : 2;
    else if (he)   win = 1;
    else if (hm)   win = 2;
    chk("ex_ready", 32'(ex_ready), 32'(!he || win == 1));
    chk("mem_ready", 32'(mem_ready), 32'(!hm || win == 2));
    e_wen = 1'b0;
    it = '{rd: '0, d: '0};
    if (win == 1) begin
      it = exq.pop_front();
      streak = 0;
    end else if (win == 2) begin
      it = mq.pop_front();
      if (he) streak++;
    end
    if (win != 0) begin
      e_wen  = (it.rd != 0);
      e_rd   = it.rd;
      e_data = it.d;
      e_cnt  = e_cnt + 32'd1;
    end
    if (ev && (!he || win == 1)) exq.push_back(res_t'{rd: erd, d: ed});
    if (mv && (!hm || win == 2)) mq.push_back(res_t'{rd: mrd, d: fmt(md, msz, mu, moff)});
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, '0, '0, 2'd0, 0, 2'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ex_valid = 1'b1;
    mem_valid = 1'b1;
    model_clear();
    #1;
    chk("rst_ex_ready", 32'(ex_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_dataD", dataD, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_ex_ready", 32'(ex_ready), 32'd0);
    chk("rst_hold_wen", 32'(wen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  logic [31:0] fexp[5] = '{32'hFFFFFF81, 32'h0000007F, 32'hFFFF80F0, 32'h000080F0, 32'h80F07F81};
  logic [1:0]  fsz[5]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  bit          fun[5]  = '{0, 1, 0, 1, 0};
  logic [1:0]  foff[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
  int          pat[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  initial begin
    int zeros, wens;
    model_clear();
    do_reset();

    // first retirement: visible one edge after the accept edge
    cycle(1, 5'd5, 32'h1234, 0, '0, '0, 2'd0, 0, 2'd0);
    idle();
    idle();
    chk("first_wen", 32'(wen), 32'd1);
    chk("first_rd", 32'(rd), 32'd5);
    chk("first_dataD", dataD, 32'h00001234);
    chk("first_retire", retire_count, 32'd1);

    for (int i = 0; i < 7; i++) begin
      if (i < 5) cycle(0, '0, '0, 1, 5'(i + 8), 32'h80F07F81, fsz[i], fun[i], foff[i]);
      else       idle();
      if (i >= 2) chk("fmt", dataD, fexp[i - 2]);
    end

    cycle(1, 5'd0, 32'hDEAD, 0, '0, '0, 2'd0, 0, 2'd0);
    cycle(1, 5'd3, 32'h0303, 0, '0, '0, 2'd0, 0, 2'd0);
    idle();
    chk("rd0_wen", 32'(wen), 32'd0);
    idle();
    chk("rd3_wen", 32'(wen), 32'd1);
    chk("rd3_rd", 32'(rd), 32'd3);

    do_reset();
    zeros = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1, 5'd1, 32'(k), 1, 5'd2, 32'(100 + k), 2'd2, 0, 2'd0);
      if (k >= 2) begin
        chk("order", 32'(rd), 32'(pat[k - 2]));
        if (!ex_ready) zeros++;
      end
    end
    chk("ex_ready_low", 32'(zeros), 32'd8);
    idle(); idle(); idle();

    wens = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, '0, '0, (k < 8), 5'(k + 1), 32'(k * 7 + 1), 2'd2, 0, 2'd0);
      if (wen) wens++;
    end
    chk("stream_wens", 32'(wens), 32'd8);

    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
    end
    idle(); idle();

    cycle(1, 5'd7, 32'h77, 1, 5'd9, 32'h99, 2'd2, 0, 2'd0);
    do_reset();
    idle();
    chk("midrst_wen", 32'(wen), 32'd0);
    chk("midrst_retire", retire_count, 32'd0);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
